rs232_tx_queue: RTL and testbench
=================================

RS232_TX_QUEUE -- requirements
Module: rs232_tx_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, 16, queue depth in bytes (power of two, at least 2); CW, log2(DEPTH)+1, width of count.
REQ-002 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 wr_data  input  8  byte to enqueue.
REQ-005 wr_en  input  1  enqueue strobe, one byte per cycle.
REQ-006 full  output  1  high when count==DEPTH.
REQ-007 empty  output  1  high when count==0.
REQ-008 count  output  CW  bytes currently stored.
REQ-009 overflow  output  1  sticky flag, set when a write is dropped.
REQ-010 data_transmit  output  8  byte presented to the transmitter.
REQ-011 start_transmit  output  1  one-cycle start pulse to the transmitter.
REQ-012 transmit_done  input  1  transmitter completion indication, level or pulse.

Function
REQ-013 The block SHALL buffer bytes in a FIFO and feed them one at a time to the transmitter, in write order.
REQ-014 Write handling: wr_en with !full stores wr_data at the tail. wr_en with full drops the byte and sets overflow. A pop in the same cycle SHALL NOT rescue a write made while full.
REQ-015 count SHALL be updated every cycle as: count + accepted write - pop. A simultaneous accepted write and pop SHALL leave count unchanged.
REQ-016 Pointers SHALL wrap modulo DEPTH. full and empty SHALL be derived from count and registered consistently with it.
REQ-017 The FSM states SHALL be IDLE, LOAD, START and WAIT.
REQ-018 IDLE: when !empty, go to LOAD; otherwise remain in IDLE.
REQ-019 LOAD: register the head byte into data_transmit, pop one entry, then go to START.
REQ-020 START: drive start_transmit=1 for exactly one cycle, then go to WAIT.
REQ-021 WAIT: go to IDLE on a rising edge of transmit_done, detected against a registered copy.
REQ-022 A transmit_done level held over from the previous byte SHALL NOT complete the current byte.
REQ-023 transmit_done SHALL be ignored outside WAIT.
REQ-024 data_transmit SHALL stay stable from LOAD until the next LOAD.
REQ-025 Latency: a write into an empty queue in IDLE at cycle N SHALL produce start_transmit high in cycle N+2.
REQ-026 Back-to-back bytes SHALL be separated by IDLE, LOAD and START after each done edge, giving a 3-cycle gap.
REQ-027 overflow SHALL clear only on rst.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL apply the following reset values:
- read pointer, write pointer and count = 0
- empty = 1, full = 0, overflow = 0
- data_transmit = 8'h00, start_transmit = 0
- FSM = IDLE, registered transmit_done copy = 0
REQ-029 Reset mid-WAIT SHALL discard the queue and return to IDLE. The transmitter is not aborted, and its pending done SHALL NOT be counted against a later byte, per REQ-021 and REQ-022.
REQ-030 wr_en SHALL be ignored in any cycle in which rst is high.

Structure
REQ-031 The shared package rs232_pkg SHALL hold the FSM state encoding and the default DEPTH constant.
REQ-032 Storage SHALL be the sub-module rs232_fifo: synchronous write and read, count, full and empty.
REQ-033 The FSM and the done edge detector SHALL reside in rs232_tx_queue.

Verification
REQ-034 Reset release, then write 8'hA5 at cycle N:
- start_transmit is pulsed once at N+2 with data_transmit=8'hA5.
- empty=1 from N+2 onward.
REQ-035 Write 8'h01, 8'h02, 8'h03 back-to-back and pulse transmit_done 10 cycles after each start:
- starts occur in order with data 01, 02, 03.
- each start comes 3 cycles after the preceding done.
REQ-036 Write 17 bytes while the transmitter holds done low:
- 16 are stored, full=1, overflow=1.
- count stays at 15 after the first LOAD.
- the 17th byte is never transmitted.
REQ-037 Hold transmit_done high continuously across LOAD and START:
- the block stays in WAIT until done falls and rises again.
REQ-038 Assert rst during WAIT with 5 bytes queued:
- count=0, start_transmit=0, overflow=0.
- no further starts occur without new writes.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 transmit queue: FSM encoding and default depth.
package rs232_pkg;

  // Default queue depth in bytes; must be a power of two and at least 2.
  localparam int DEFAULT_DEPTH = 16;

  // Byte-feeding FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/rs232_fifo.sv
// Byte FIFO with inferred RAM (registered read), wrapping pointers and a
// registered count from which full and empty are derived.
module rs232_fifo
  import rs232_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [0:DEPTH-1];
  logic [7:0]    rd_data_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          wr_accept;
  logic          rd_accept;

  // A write while full is dropped even if a pop happens in the same cycle,
  // because the decision uses the registered full flag.
  assign wr_accept = wr_en && !full_reg && !rst;
  assign rd_accept = rd_en && !empty_reg;

  // Next count: +1 for an accepted write, -1 for a pop, unchanged for both.
  always_comb begin
    count_next = count_reg;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Storage array: synchronous write, registered read of the current head.
  // The head is re-read every cycle so rd_data always reflects rd_ptr one
  // cycle later; the consumer waits at least one cycle after any pointer move.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    rd_data_reg <= mem[rd_ptr_reg];
  end

  // Pointers, count and the flags derived from the next count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = rd_data_reg;
  assign count   = count_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/rs232_tx_queue.sv
// RS-232 transmit queue: buffers bytes and hands them one at a time to the
// transmitter, waiting for a rising edge of transmit_done between bytes.
module rs232_tx_queue
  import rs232_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data,
  input  logic          wr_en,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic [7:0]    data_transmit,
  output logic          start_transmit,
  input  logic          transmit_done
);

  tx_state_t  state_reg;
  tx_state_t  state_next;
  logic       done_prev_reg;
  logic       done_rise;
  logic       pop;
  logic       overflow_reg;
  logic [7:0] data_transmit_reg;
  logic       start_transmit_reg;
  logic [7:0] head_data;
  logic       fifo_full;
  logic       fifo_empty;

  rs232_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (wr_data),
    .wr_en   (wr_en),
    .rd_en   (pop),
    .rd_data (head_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A done level carried over from an earlier byte never looks like a rise.
  assign done_rise = transmit_done && !done_prev_reg;

  // Next-state logic; transmit_done only matters in WAIT.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        pop        = 1'b1;
        state_next = START;
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, done history, and registered transmitter-facing outputs.
  // start_transmit is registered from the next state so it is high exactly
  // while the FSM sits in START, without a combinational output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      done_prev_reg      <= 1'b0;
      data_transmit_reg  <= 8'h00;
      start_transmit_reg <= 1'b0;
    end else begin
      state_reg          <= state_next;
      done_prev_reg      <= transmit_done;
      start_transmit_reg <= (state_next == START);
      if (state_reg == LOAD) begin
        data_transmit_reg <= head_data;
      end
    end
  end

  // Sticky overflow: set by any write attempted while full, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_en && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

  assign full           = fifo_full;
  assign empty          = fifo_empty;
  assign overflow       = overflow_reg;
  assign data_transmit  = data_transmit_reg;
  assign start_transmit = start_transmit_reg;

endmodule

// File: tb/tb_rs232_tx_queue.sv
// Directed self-checking bench for rs232_tx_queue.
// Inputs change 1 time unit after a rising edge; start pulses are logged on
// the falling edge together with the cycle number (incremented each rising edge).
module tb_rs232_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    wr_data;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    data_transmit;
  logic          start_transmit;
  logic          transmit_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] st_data [$];
  int         st_cyc  [$];

  rs232_tx_queue #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .data_transmit  (data_transmit),
    .start_transmit (start_transmit),
    .transmit_done  (transmit_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // One line per start pulse seen by the transmitter.
  always @(negedge clk) begin
    if (start_transmit) begin
      st_data.push_back(data_transmit);
      st_cyc.push_back(cyc);
      $display("start cyc=%0d data=%02h count=%0d", cyc, data_transmit, count);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After return, cyc is the edge number that sampled the write.
  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  // Wait (bounded) until n start pulses have been logged.
  task automatic wait_starts(input int n, input string tag);
    int budget = 200;
    while (st_data.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check_eq(tag, st_data.size(), n);
  endtask

  // Drive a one-cycle done pulse visible during cycle `target`; returns that cycle.
  task automatic pulse_done_at(input int target, output int dcyc);
    while (cyc < target) tick();
    transmit_done = 1'b1;
    dcyc          = cyc;
    tick();
    transmit_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n1;
    int dcyc;
    rst           = 1'b1;
    wr_data       = 8'h00;
    wr_en         = 1'b0;
    transmit_done = 1'b0;

    // Reset state; a write strobe during reset must be ignored.
    wr_data = 8'hEE;
    wr_en   = 1'b1;
    repeat (3) tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_data", data_transmit, 8'h00);
    check_eq("rst_start", start_transmit, 0);
    rst   = 1'b0;
    wr_en = 1'b0;
    tick();
    check_eq("rst_wr_ignored", count, 0);

    // Single byte: start at N+2 with A5, queue empty from N+2.
    write_byte(8'hA5);
    n1 = cyc;
    check_eq("a5_count_n", count, 1);
    tick();
    tick();
    check_eq("a5_start_n2", start_transmit, 1);
    check_eq("a5_data_n2", data_transmit, 8'hA5);
    check_eq("a5_empty_n2", empty, 1);
    tick();
    check_eq("a5_start_n3", start_transmit, 0);
    check_eq("a5_empty_n3", empty, 1);
    check_eq("a5_data_n3", data_transmit, 8'hA5);
    pulse_done_at(cyc, dcyc);
    check_eq("a5_one_start", st_data.size(), 1);

    // Three bytes back to back; done pulsed 10 cycles after each start.
    tick();
    st_data.delete();
    st_cyc.delete();
    write_byte(8'h01);
    n1 = cyc;
    write_byte(8'h02);
    write_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      wait_starts(i + 1, "b2b_timeout");
      if (st_data.size() < i + 1) break;
      if (i == 0) check_eq("b2b_first_lat", st_cyc[0] - n1, 2);
      else        check_eq("b2b_gap", st_cyc[i] - dcyc, 3);
      check_eq("b2b_data", st_data[i], 8'(i + 1));
      pulse_done_at(st_cyc[i] + 10, dcyc);
    end
    repeat (5) tick();
    check_eq("b2b_total", st_data.size(), 3);

    // Overflow: one byte in flight, then 17 writes with done held low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    st_data.delete();
    st_cyc.delete();
    write_byte(8'h10);
    wait_starts(1, "ovf_first_timeout");
    for (int k = 0; k < 17; k++) write_byte(8'(8'h20 + k));
    check_eq("ovf_count16", count, 16);
    check_eq("ovf_full", full, 1);
    check_eq("ovf_flag", overflow, 1);
    pulse_done_at(cyc, dcyc);
    while (cyc < dcyc + 3) tick();
    check_eq("ovf_count15", count, 15);
    check_eq("ovf_full_clr", full, 0);
    check_eq("ovf_start", start_transmit, 1);
    for (int k = 1; k <= 16; k++) begin
      wait_starts(k + 1, "ovf_drain_timeout");
      if (st_data.size() < k + 1) break;
      check_eq("ovf_order", st_data[k], 8'(8'h1F + k));
      pulse_done_at(st_cyc[k] + 2, dcyc);
    end
    repeat (30) tick();
    check_eq("ovf_no17th", st_data.size(), 17);
    check_eq("ovf_empty", empty, 1);
    check_eq("ovf_sticky", overflow, 1);

    // Reset in WAIT with 5 bytes queued (overflow still set from above).
    st_data.delete();
    st_cyc.delete();
    for (int k = 0; k < 6; k++) write_byte(8'(8'h50 + k));
    wait_starts(1, "mid_first_timeout");
    check_eq("mid_count5", count, 5);
    rst     = 1'b1;
    wr_data = 8'h77;
    wr_en   = 1'b1;
    tick();
    rst   = 1'b0;
    wr_en = 1'b0;
    check_eq("mid_count0", count, 0);
    check_eq("mid_start0", start_transmit, 0);
    check_eq("mid_ovf0", overflow, 0);
    check_eq("mid_empty", empty, 1);
    repeat (5) tick();
    pulse_done_at(cyc, dcyc);
    repeat (30) tick();
    check_eq("mid_no_starts", st_data.size(), 1);
    check_eq("mid_count_end", count, 0);

    // Done held high across LOAD and START must not complete the byte.
    st_data.delete();
    st_cyc.delete();
    transmit_done = 1'b1;
    tick();
    write_byte(8'h41);
    write_byte(8'h42);
    wait_starts(1, "hold_first_timeout");
    if (st_data.size() >= 1) check_eq("hold_data1", st_data[0], 8'h41);
    repeat (10) tick();
    check_eq("hold_stuck", st_data.size(), 1);
    check_eq("hold_count", count, 1);
    transmit_done = 1'b0;
    tick();
    transmit_done = 1'b1;
    dcyc = cyc;
    wait_starts(2, "hold_second_timeout");
    if (st_data.size() >= 2) begin
      check_eq("hold_gap", st_cyc[1] - dcyc, 3);
      check_eq("hold_data2", st_data[1], 8'h42);
    end
    repeat (10) tick();
    transmit_done = 1'b0;
    tick();
    transmit_done = 1'b1;
    tick();
    transmit_done = 1'b0;
    repeat (5) tick();
    check_eq("hold_total", st_data.size(), 2);
    check_eq("hold_empty", empty, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
